// File: rtl/oai21_cell_sequencer.sv
// Sequencer for exercising a single OAI21 cell (Y = ~((A|B)&C)) under test.
//
// Each run drives the cell inputs through all eight vectors, 000 to 111, in
// order. The cell output goes through a 2-flop synchronizer and is compared
// with the golden value. The sequencer records the worst matching latency
// and counts vectors that time out.
//
// Ports:
//   clk_i      clock; all state changes on the rising edge
//   rst_ni     asynchronous active-low reset
//   start_i    begin a run; sampled only when idle or done
//   y_i        cell-under-test output (asynchronous to clk_i)
//   a_o/b_o/c_o  cell-under-test inputs (vec[2]/vec[1]/vec[0]), registered
//   busy_o     high while waiting on a vector response
//   done_o     level, high from end of run until the next start
//   fail_o     sticky, set by any timeout during the run
//   errcnt_o   number of timed-out vectors, saturating
//   failvec_o  first vector that timed out (valid when fail_o=1)
//   maxlat_o   largest matched latency in the run
module oai21_cell_sequencer #(
  parameter int unsigned LW  = 4,
  parameter int unsigned TMO = 15,
  parameter int unsigned EW  = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          y_i,
  output logic          a_o,
  output logic          b_o,
  output logic          c_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          fail_o,
  output logic [EW-1:0] errcnt_o,
  output logic [2:0]    failvec_o,
  output logic [LW-1:0] maxlat_o
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [LW-1:0] TmoVal = LW'(TMO);
  localparam logic [LW-1:0] MinLat = LW'(2);

  state_e        state_q;
  logic [2:0]    vec_q;
  logic [LW-1:0] lat_q;
  logic          ys1_q, ys2_q;
  logic          busy_q, done_q, fail_q;
  logic [EW-1:0] errcnt_q;
  logic [2:0]    failvec_q;
  logic [LW-1:0] maxlat_q;

  logic exp_bit;
  logic match;
  logic timeout;

  // Golden response for the vector currently on the cell inputs.
  assign exp_bit = ~((vec_q[2] | vec_q[1]) & vec_q[0]);

  // For the first two cycles after a vector change the synchronizer still
  // carries the previous vector's response, so those compares are masked.
  assign match   = (lat_q >= MinLat) && (ys2_q == exp_bit);
  assign timeout = !match && (lat_q == TmoVal);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      vec_q     <= 3'd0;
      lat_q     <= '0;
      ys1_q     <= 1'b0;
      ys2_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      errcnt_q  <= '0;
      failvec_q <= 3'd0;
      maxlat_q  <= '0;
    end else begin
      ys1_q <= y_i;
      ys2_q <= ys1_q;
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q   <= StWait;
            vec_q     <= 3'd0;
            lat_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            errcnt_q  <= '0;
            failvec_q <= 3'd0;
            maxlat_q  <= '0;
          end
        end
        StWait: begin
          if (match || timeout) begin
            if (match && (lat_q > maxlat_q)) begin
              maxlat_q <= lat_q;
            end
            if (timeout) begin
              if (errcnt_q != '1) begin
                errcnt_q <= errcnt_q + EW'(1);
              end
              if (!fail_q) begin
                failvec_q <= vec_q;
              end
              fail_q <= 1'b1;
            end
            if (vec_q == 3'd7) begin
              // Last vector: cell inputs stay at 111 while done.
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              vec_q <= vec_q + 3'd1;
              lat_q <= '0;
            end
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a_o       = vec_q[2];
  assign b_o       = vec_q[1];
  assign c_o       = vec_q[0];
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign fail_o    = fail_q;
  assign errcnt_o  = errcnt_q;
  assign failvec_o = failvec_q;
  assign maxlat_o  = maxlat_q;

endmodule

// File: tb/tb_oai21_cell_sequencer.sv
// Bench for oai21_cell_sequencer. Two instances run side by side: one with
// default parameters and one with TMO=4, EW=2. Each drives its own cell model,
// which is ideal, delayed, or stuck. Expected timing and results come from a
// per-vector schedule computed from the cell behaviour.
module tb_oai21_cell_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  always #5 clk = ~clk;

  // Cell model selection: 0 = OAI21 delayed by d cycles, 1 = stuck-0, 2 = stuck-1.
  int mode = 0;
  int d_big = 0;
  int d_sml = 0;

  logic [2:0] abc_w [2];
  logic       y_w [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       fail_w [2];
  logic [2:0] failvec_w [2];
  logic [3:0] maxlat_w [2];
  logic [3:0] errcnt_big;
  logic [1:0] errcnt_sml;

  oai21_cell_sequencer #(.LW(4), .TMO(15), .EW(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .y_i(y_w[0]),
    .a_o(abc_w[0][2]), .b_o(abc_w[0][1]), .c_o(abc_w[0][0]),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .fail_o(fail_w[0]),
    .errcnt_o(errcnt_big), .failvec_o(failvec_w[0]), .maxlat_o(maxlat_w[0])
  );

  oai21_cell_sequencer #(.LW(4), .TMO(4), .EW(2)) u_dut_sml (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .y_i(y_w[1]),
    .a_o(abc_w[1][2]), .b_o(abc_w[1][1]), .c_o(abc_w[1][0]),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .fail_o(fail_w[1]),
    .errcnt_o(errcnt_sml), .failvec_o(failvec_w[1]), .maxlat_o(maxlat_w[1])
  );

  function automatic logic oai(input logic [2:0] v);
    return ~((v[2] | v[1]) & v[0]);
  endfunction

  // Registered delay lines behind each cell.
  logic [15:0] ch_big, ch_sml;
  always @(posedge clk) begin
    ch_big <= {ch_big[14:0], oai(abc_w[0])};
    ch_sml <= {ch_sml[14:0], oai(abc_w[1])};
  end

  always_comb begin
    y_w[0] = 1'b0;
    y_w[1] = 1'b0;
    if (mode == 1) begin
      y_w[0] = 1'b0;
      y_w[1] = 1'b0;
    end else if (mode == 2) begin
      y_w[0] = 1'b1;
      y_w[1] = 1'b1;
    end else begin
      y_w[0] = (d_big == 0) ? oai(abc_w[0]) : ch_big[d_big-1];
      y_w[1] = (d_sml == 0) ? oai(abc_w[1]) : ch_sml[d_sml-1];
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference schedule: per-vector start offset from the START edge, and run results.
  int         exp_start [2][9];
  int         exp_total [2];
  int         exp_err [2];
  logic       exp_fail [2];
  logic [2:0] exp_fvec [2];
  int         exp_maxlat [2];
  logic [2:0] idle_abc = 3'd0;

  task automatic predict(input int idx, input int m, input int d, input int tmo,
                         input int errmax, input logic [2:0] idle_v);
    logic prev, e, ok;
    int l, t;
    prev = oai(idle_v);
    t = 0;
    exp_err[idx] = 0;
    exp_fail[idx] = 1'b0;
    exp_fvec[idx] = 3'd0;
    exp_maxlat[idx] = 0;
    for (int v = 0; v < 8; v++) begin
      exp_start[idx][v] = t;
      e = oai(3'(v));
      if (m == 0) begin
        // Unchanged response is already in the synchronizer; a change needs d+2.
        l = (e == prev) ? 2 : d + 2;
        ok = (l <= tmo);
      end else begin
        l = 2;
        ok = (e == (m == 2));
      end
      if (ok) begin
        t += l + 1;
        if (l > exp_maxlat[idx]) exp_maxlat[idx] = l;
      end else begin
        t += tmo + 1;
        if (exp_err[idx] < errmax) exp_err[idx]++;
        if (!exp_fail[idx]) exp_fvec[idx] = 3'(v);
        exp_fail[idx] = 1'b1;
      end
      prev = e;
    end
    exp_start[idx][8] = t;
    exp_total[idx] = t;
  endtask

  function automatic logic [2:0] exp_vec(input int idx, input int k);
    for (int v = 7; v > 0; v--) if (k >= exp_start[idx][v]) return 3'(v);
    return 3'd0;
  endfunction

  function automatic logic [31:0] errcnt_of(input int idx);
    return (idx == 0) ? 32'(errcnt_big) : 32'(errcnt_sml);
  endfunction

  task automatic check_cycle(input int idx, input int k);
    string s;
    s = $sformatf("u%0d k=%0d", idx, k);
    check_eq({s, " busy"}, 32'(busy_w[idx]), 32'(k < exp_total[idx]));
    check_eq({s, " done"}, 32'(done_w[idx]), 32'(k >= exp_total[idx]));
    check_eq({s, " abc"}, 32'(abc_w[idx]), 32'(exp_vec(idx, k)));
  endtask

  task automatic check_cleared(input int idx);
    check_eq($sformatf("u%0d start-clr err", idx), errcnt_of(idx), 32'd0);
    check_eq($sformatf("u%0d start-clr fail", idx), 32'(fail_w[idx]), 32'd0);
    check_eq($sformatf("u%0d start-clr fvec", idx), 32'(failvec_w[idx]), 32'd0);
    check_eq($sformatf("u%0d start-clr maxlat", idx), 32'(maxlat_w[idx]), 32'd0);
  endtask

  task automatic check_results(input int idx);
    check_eq($sformatf("u%0d errcnt", idx), errcnt_of(idx), 32'(exp_err[idx]));
    check_eq($sformatf("u%0d fail", idx), 32'(fail_w[idx]), 32'(exp_fail[idx]));
    check_eq($sformatf("u%0d failvec", idx), 32'(failvec_w[idx]), 32'(exp_fvec[idx]));
    check_eq($sformatf("u%0d maxlat", idx), 32'(maxlat_w[idx]), 32'(exp_maxlat[idx]));
  endtask

  // One full run; repulse re-asserts START for one cycle in the middle of WAIT.
  task automatic run(input int m, input int d, input bit repulse);
    int kmax;
    mode = m;
    d_big = d;
    d_sml = (d > 2) ? 2 : d;
    predict(0, m, d_big, 15, 15, idle_abc);
    predict(1, m, d_sml, 4, 3, idle_abc);
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) check_cleared(i);
    kmax = ((exp_total[0] > exp_total[1]) ? exp_total[0] : exp_total[1]) + 2;
    for (int k = 0; k <= kmax; k++) begin
      for (int i = 0; i < 2; i++) check_cycle(i, k);
      start = repulse && (k == 6);
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 2; i++) check_results(i);
    idle_abc = 3'd7;
  endtask

  // Reset dropped mid-run while stuck-0 has already produced timeouts.
  task automatic reset_midrun();
    mode = 1;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("pre-reset u1 errcnt nonzero", 32'(errcnt_sml != 2'd0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d async rst abc", i), 32'(abc_w[i]), 32'd0);
      check_eq($sformatf("u%0d async rst busy", i), 32'(busy_w[i]), 32'd0);
      check_eq($sformatf("u%0d async rst done", i), 32'(done_w[i]), 32'd0);
      check_eq($sformatf("u%0d async rst err", i), errcnt_of(i), 32'd0);
      check_eq($sformatf("u%0d async rst fail", i), 32'(fail_w[i]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d idle busy", i), 32'(busy_w[i]), 32'd0);
      check_eq($sformatf("u%0d idle done", i), 32'(done_w[i]), 32'd0);
      check_eq($sformatf("u%0d idle abc", i), 32'(abc_w[i]), 32'd0);
    end
    idle_abc = 3'd0;
  endtask

  initial begin
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d reset busy", i), 32'(busy_w[i]), 32'd0);
      check_eq($sformatf("u%0d reset done", i), 32'(done_w[i]), 32'd0);
      check_eq($sformatf("u%0d reset abc", i), 32'(abc_w[i]), 32'd0);
      check_eq($sformatf("u%0d reset err", i), errcnt_of(i), 32'd0);
      check_eq($sformatf("u%0d reset maxlat", i), 32'(maxlat_w[i]), 32'd0);
    end
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    run(0, 0, 1'b0);  // ideal cell
    run(0, 3, 1'b0);  // 3-cycle delayed cell
    run(2, 0, 1'b0);  // stuck-at-1
    run(1, 0, 1'b0);  // stuck-at-0, saturates the EW=2 counter
    run(0, 0, 1'b1);  // START re-pulsed during WAIT
    reset_midrun();
    for (int r = 0; r < 10; r++) begin
      run(int'($urandom_range(0, 2)), int'($urandom_range(0, 13)), 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
